threshold_alarm: RTL and testbench



---
 rtl/threshold_alarm_pkg.sv | 17 +
 rtl/threshold_alarm_classify.sv | 38 +++
 rtl/threshold_alarm.sv | 133 +++++++++++++
 tb/tb_threshold_alarm.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/threshold_alarm_pkg.sv
// Shared encodings for the threshold alarm block: class codes, FSM states
// and the 2-bit magnitude-compare slice the comparators are tiled from.
package threshold_alarm_pkg;

  localparam logic [1:0] CLS_IN    = 2'b00;
  localparam logic [1:0] CLS_BELOW = 2'b01;
  localparam logic [1:0] CLS_ABOVE = 2'b10;
  localparam logic [1:0] CLS_BAD   = 2'b11;

  typedef enum logic [1:0] {OK, PEND, ALARM} state_e;

  // {a > b, a < b} for one 2-bit slice; 00 means the slice is equal
  function automatic logic [1:0] slice_cmp(input logic [1:0] a, input logic [1:0] b);
    return {a > b, a < b};
  endfunction

endpackage

// File: rtl/threshold_alarm_classify.sv
// Combinational window classifier: below / in-range / above against [lo, hi],
// each bound checked by a less-than built from 2-bit slices, MSB first.
module range_classify
  import threshold_alarm_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [1:0]       cls
);

  localparam int NS = WIDTH / 2;

  // The most significant unequal slice decides; lower slices are ignored.
  function automatic logic wide_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [1:0] r;
    logic [1:0] s;
    r = 2'b00;
    for (int i = NS - 1; i >= 0; i--) begin
      s = slice_cmp(a[2*i +: 2], b[2*i +: 2]);
      if (r == 2'b00) r = s;
    end
    return r[0];
  endfunction

  logic below, above;

  always_comb begin
    below = wide_lt(data, lo);
    above = wide_lt(hi, data);
    cls   = CLS_IN;
    if (below)      cls = CLS_BELOW;
    else if (above) cls = CLS_ABOVE;
  end

endmodule

// File: rtl/threshold_alarm.sv
// Windowed sample classifier with a 1-deep output register behind valid/ready
// and a debounced, sticky-until-recovered alarm with a saturating event count.
module threshold_alarm
  import threshold_alarm_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = 3,
  parameter int EVT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_lo,
  input  logic [WIDTH-1:0] cfg_hi,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [1:0]       out_cls,
  input  logic             out_ready,
  output logic             alarm,
  output logic             cfg_err,
  output logic [EVT_W-1:0] evt_cnt
);

  localparam int RUN_W = 4;
  localparam logic [RUN_W-1:0] DB = RUN_W'(DEBOUNCE);

  logic [WIDTH-1:0] lo_q, hi_q;
  logic [1:0]       cls_raw, cls;
  logic             acc, qual, is_out, evt_inc;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  state_e           state_q, state_d;

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;

  range_classify #(.WIDTH(WIDTH)) u_cls (
    .data (in_data),
    .lo   (lo_q),
    .hi   (hi_q),
    .cls  (cls_raw)
  );

  // cfg_err mirrors the stored bounds, so it gates classification directly
  assign cls     = cfg_err ? CLS_BAD : cls_raw;
  assign is_out  = (cls_raw != CLS_IN);
  assign qual    = acc && !cfg_err && !cfg_we;
  assign run_inc = run_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q    <= '0;
      hi_q    <= '1;
      cfg_err <= 1'b0;
    end else if (cfg_we) begin
      lo_q    <= cfg_lo;
      hi_q    <= cfg_hi;
      cfg_err <= (cfg_lo > cfg_hi);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_cls   <= CLS_IN;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_cls   <= cls;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OK;
      run_q   <= '0;
      alarm   <= 1'b0;
      evt_cnt <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      alarm   <= (state_d == ALARM);
      if (evt_inc && evt_cnt != '1) evt_cnt <= evt_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    evt_inc = 1'b0;
    if (cfg_we) begin
      state_d = OK;
      run_d   = '0;
    end else if (qual) begin
      unique case (state_q)
        OK: if (is_out) begin
          if (DB == 1) begin
            state_d = ALARM;
            evt_inc = 1'b1;
          end else begin
            state_d = PEND;
            run_d   = 1;
          end
        end
        PEND: if (!is_out) begin
          state_d = OK;
          run_d   = '0;
        end else if (run_inc == DB) begin
          state_d = ALARM;
          run_d   = '0;
          evt_inc = 1'b1;
        end else begin
          run_d   = run_inc;
        end
        ALARM: if (is_out) begin
          run_d   = '0;
        end else if (run_inc == DB) begin
          state_d = OK;
          run_d   = '0;
        end else begin
          run_d   = run_inc;
        end
        default: begin
          state_d = OK;
          run_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_threshold_alarm.sv
// Bench for threshold_alarm: directed vector table, async-reset checks and a
// randomized run against a sliding-window reference model.
module tb_threshold_alarm;

  localparam int W = 4;
  localparam int D = 3;
  localparam int E = 8;

  logic         clk, rst, cfg_we, in_valid, in_ready, out_valid, out_ready;
  logic         alarm, cfg_err;
  logic [W-1:0] cfg_lo, cfg_hi, in_data;
  logic [1:0]   out_cls;
  logic [E-1:0] evt_cnt;

  threshold_alarm #(.WIDTH(W), .DEBOUNCE(D), .EVT_W(E)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_cls(out_cls), .out_ready(out_ready),
    .alarm(alarm), .cfg_err(cfg_err), .evt_cnt(evt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         we;
    logic [W-1:0] lo, hi;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         e_rdy, e_ov;
    logic [1:0]   e_cls;
    logic         e_al, e_err;
    logic [E-1:0] e_evt;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Reference: the alarm toggles whenever the last D qualifying samples since
  // the previous toggle (or cfg/reset) all have the "wanted" out-of-rangeness.
  logic [W-1:0] m_lo, m_hi;
  logic         m_ov, m_alarm;
  logic [1:0]   m_cls;
  int           m_evt;
  bit           hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lo = '0; m_hi = '1; m_ov = 0; m_cls = 2'b00; m_alarm = 0; m_evt = 0;
    hist.delete();
  endtask

  task automatic model_step(input vec_t v);
    logic       rdy, acc, bad, all;
    logic [1:0] c;
    rdy = !m_ov || v.ordy;
    acc = v.iv && rdy;
    bad = m_lo > m_hi;
    c   = bad ? 2'b11 : (v.d < m_lo) ? 2'b01 : (v.d > m_hi) ? 2'b10 : 2'b00;
    if (acc) begin m_ov = 1; m_cls = c; end
    else if (v.ordy) m_ov = 0;
    if (v.we) begin
      m_lo = v.lo; m_hi = v.hi; m_alarm = 0;
      hist.delete();
    end else if (acc && !bad) begin
      hist.push_back(c != 2'b00);
      if (hist.size() >= D) begin
        all = 1;
        for (int k = 0; k < D; k++)
          if (hist[hist.size()-1-k] != !m_alarm) all = 0;
        if (all) begin
          if (!m_alarm && m_evt < (1 << E) - 1) m_evt++;
          m_alarm = !m_alarm;
          hist.delete();
        end
      end
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, " out_cls"},   32'(out_cls),   32'(m_cls));
    chk({tag, " alarm"},     32'(alarm),     32'(m_alarm));
    chk({tag, " cfg_err"},   32'(cfg_err),   32'(m_lo > m_hi));
    chk({tag, " evt_cnt"},   32'(evt_cnt),   32'(m_evt));
  endtask

  // Entered at posedge+1; leaves at the following posedge+1.
  task automatic step(input vec_t v, input bit use_tbl, input string tag);
    cfg_we = v.we; cfg_lo = v.lo; cfg_hi = v.hi;
    in_valid = v.iv; in_data = v.d; out_ready = v.ordy;
    #1;
    chk({tag, " in_ready"}, 32'(in_ready), 32'(!m_ov || v.ordy));
    if (use_tbl) chk({tag, " tbl in_ready"}, 32'(in_ready), 32'(v.e_rdy));
    @(posedge clk);
    model_step(v);
    #1;
    check_outs(tag);
    if (use_tbl) begin
      chk({tag, " tbl out_valid"}, 32'(out_valid), 32'(v.e_ov));
      chk({tag, " tbl out_cls"},   32'(out_cls),   32'(v.e_cls));
      chk({tag, " tbl alarm"},     32'(alarm),     32'(v.e_al));
      chk({tag, " tbl cfg_err"},   32'(cfg_err),   32'(v.e_err));
      chk({tag, " tbl evt_cnt"},   32'(evt_cnt),   32'(v.e_evt));
    end
    cfg_we = 0;
  endtask

  // Reset raised mid-cycle; outputs must clear before any clock edge.
  task automatic mid_reset(input string tag);
    #3 rst = 1;
    #1;
    model_reset();
    chk({tag, " async alarm"},     32'(alarm),     32'(0));
    chk({tag, " async out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, " async evt_cnt"},   32'(evt_cnt),   32'(0));
    @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic add(input logic we, input int lo, input int hi, input logic iv,
                     input int d, input logic ordy, input logic rdy, input logic ov,
                     input int c, input logic al, input logic er, input int ev);
    vec_t v;
    v.we = we; v.lo = W'(lo); v.hi = W'(hi); v.iv = iv; v.d = W'(d); v.ordy = ordy;
    v.e_rdy = rdy; v.e_ov = ov; v.e_cls = 2'(c); v.e_al = al; v.e_err = er; v.e_evt = E'(ev);
    tbl.push_back(v);
  endtask

  initial begin
    vec_t rv;
    rst = 1; cfg_we = 0; cfg_lo = 0; cfg_hi = 0; in_valid = 0; in_data = 0; out_ready = 1;
    model_reset();

    //  we lo hi iv  d or | rdy ov cls al err evt
    add(1, 3, 12, 0,  0, 1,  1, 0, 0, 0, 0, 0);
    add(0, 0,  0, 1,  3, 1,  1, 1, 0, 0, 0, 0);
    add(0, 0,  0, 1, 12, 1,  1, 1, 0, 0, 0, 0);
    add(0, 0,  0, 1,  2, 1,  1, 1, 1, 0, 0, 0);
    add(0, 0,  0, 1, 13, 1,  1, 1, 2, 0, 0, 0);
    add(0, 0,  0, 1,  7, 1,  1, 1, 0, 0, 0, 0);
    add(0, 0,  0, 1, 15, 1,  1, 1, 2, 0, 0, 0);
    add(0, 0,  0, 1,  0, 1,  1, 1, 1, 0, 0, 0);
    add(0, 0,  0, 1, 14, 1,  1, 1, 2, 1, 0, 1);
    add(0, 0,  0, 1,  5, 1,  1, 1, 0, 1, 0, 1);
    add(0, 0,  0, 1,  6, 1,  1, 1, 0, 1, 0, 1);
    add(0, 0,  0, 1,  7, 1,  1, 1, 0, 0, 0, 1);
    add(0, 0,  0, 1, 15, 1,  1, 1, 2, 0, 0, 1);
    add(0, 0,  0, 1, 15, 1,  1, 1, 2, 0, 0, 1);
    add(0, 0,  0, 1,  5, 1,  1, 1, 0, 0, 0, 1);
    add(0, 0,  0, 1, 15, 1,  1, 1, 2, 0, 0, 1);
    add(0, 0,  0, 1, 15, 1,  1, 1, 2, 0, 0, 1);
    add(0, 0,  0, 1,  9, 0,  0, 1, 2, 0, 0, 1);
    add(0, 0,  0, 1,  9, 0,  0, 1, 2, 0, 0, 1);
    add(0, 0,  0, 1, 15, 1,  1, 1, 2, 1, 0, 2);
    add(0, 0,  0, 1,  9, 1,  1, 1, 0, 1, 0, 2);
    add(0, 0,  0, 0,  0, 1,  1, 0, 0, 1, 0, 2);
    add(1, 10, 4, 0,  0, 1,  1, 0, 0, 0, 1, 2);
    add(0, 0,  0, 1,  0, 1,  1, 1, 3, 0, 1, 2);
    add(0, 0,  0, 1, 15, 1,  1, 1, 3, 0, 1, 2);
    add(1, 4, 10, 0,  0, 1,  1, 0, 3, 0, 0, 2);
    add(1, 4, 10, 1, 15, 1,  1, 1, 2, 0, 0, 2);
    add(0, 0,  0, 1,  0, 1,  1, 1, 1, 0, 0, 2);
    add(0, 0,  0, 1,  0, 1,  1, 1, 1, 0, 0, 2);
    add(0, 0,  0, 1,  0, 1,  1, 1, 1, 1, 0, 3);

    #12;
    check_outs("reset");
    @(posedge clk);
    #1 rst = 0;

    foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("vec%0d", i));
    mid_reset("directed");

    for (int n = 0; n < 3000; n++) begin
      rv.we   = ($urandom_range(0, 39) == 0);
      rv.lo   = W'($urandom_range(0, 7));
      rv.hi   = W'($urandom_range(5, 15));
      if ($urandom_range(0, 7) == 0) begin
        rv.lo = W'($urandom_range(8, 15));
        rv.hi = W'($urandom_range(0, 7));
      end
      rv.iv   = ($urandom_range(0, 3) != 0);
      rv.d    = W'($urandom_range(0, 15));
      rv.ordy = ($urandom_range(0, 3) != 0);
      step(rv, 1'b0, "rand");
      if (n % 1000 == 999) mid_reset("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
